// File: rtl/fpu_addsub_seq.sv
// Iterative binary32 add/subtract; one-bit-per-clock alignment and normalization.
// Define FPU_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module fpu_addsub_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  localparam int unsigned EXP_W = 10;
  localparam int unsigned MAN_W = 27;
  localparam int unsigned SUM_W = 28;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_ALIGN  = 3'd2;
  localparam logic [2:0] S_ADD    = 3'd3;
  localparam logic [2:0] S_NORM   = 3'd4;
  localparam logic [2:0] S_ROUND  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]              state_q, state_d;
  logic [31:0]             opa_q, opa_d, opb_q, opb_d;
  logic                    sign_q, sign_d;
  logic                    eff_sub_q, eff_sub_d;
  logic                    zero_q, zero_d;
  logic signed [EXP_W-1:0] exp_q, exp_d;
  logic [MAN_W-1:0]        mx_q, mx_d, my_q, my_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic [31:0]             result_q, result_d;
  logic [2:0]              flags_q, flags_d;

  // Operand decode, flush-to-zero and magnitude ordering for UNPACK
  logic [7:0]  ea_c, eb_c, ex_c, ey_c, diff_c;
  logic [22:0] fa_c, fb_c, fx_c, fy_c;
  logic        a_nan_c, b_nan_c, a_inf_c, b_inf_c, a_ge_c, sx_c, sy_c;
  logic [CNT_W-1:0] dcl_c;

  assign ea_c    = opa_q[30:23];
  assign eb_c    = opb_q[30:23];
  assign fa_c    = (ea_c == 8'd0) ? 23'd0 : opa_q[22:0];
  assign fb_c    = (eb_c == 8'd0) ? 23'd0 : opb_q[22:0];
  assign a_nan_c = (ea_c == 8'hFF) && (opa_q[22:0] != 23'd0);
  assign b_nan_c = (eb_c == 8'hFF) && (opb_q[22:0] != 23'd0);
  assign a_inf_c = (ea_c == 8'hFF) && (opa_q[22:0] == 23'd0);
  assign b_inf_c = (eb_c == 8'hFF) && (opb_q[22:0] == 23'd0);
  assign a_ge_c  = {ea_c, fa_c} >= {eb_c, fb_c};
  assign ex_c    = a_ge_c ? ea_c : eb_c;
  assign ey_c    = a_ge_c ? eb_c : ea_c;
  assign fx_c    = a_ge_c ? fa_c : fb_c;
  assign fy_c    = a_ge_c ? fb_c : fa_c;
  assign sx_c    = a_ge_c ? opa_q[31] : opb_q[31];
  assign sy_c    = a_ge_c ? opb_q[31] : opa_q[31];
  assign diff_c  = ex_c - ey_c;
  assign dcl_c   = (diff_c > 8'd26) ? 5'd26 : diff_c[4:0];

  // Mantissa add and rounding datapath
  logic [SUM_W-1:0]        sum_c;
  logic                    round_inc_c;
  logic [24:0]             rnd_c;
  logic signed [EXP_W-1:0] exp_fin_c;
  logic [22:0]             man_fin_c;

  assign sum_c = eff_sub_q ? (SUM_W'({1'b0, mx_q}) - SUM_W'({1'b0, my_q}))
                           : (SUM_W'({1'b0, mx_q}) + SUM_W'({1'b0, my_q}));

`ifdef FPU_ROUND_NEAREST_EN
  assign round_inc_c = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
`else
  assign round_inc_c = 1'b0;
`endif

  assign rnd_c     = {1'b0, sum_q[26:3]} + 25'(round_inc_c);
  assign exp_fin_c = exp_q + $signed({9'd0, rnd_c[24]});
  assign man_fin_c = rnd_c[24] ? rnd_c[23:1] : rnd_c[22:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      zero_q    <= 1'b0;
      exp_q     <= '0;
      mx_q      <= '0;
      my_q      <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
      flags_q   <= 3'd0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      zero_q    <= zero_d;
      exp_q     <= exp_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    zero_d    = zero_q;
    exp_d     = exp_q;
    mx_d      = mx_q;
    my_d      = my_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    flags_d   = flags_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = {b[31] ^ op_sub, b[30:0]};
          busy_d  = 1'b1;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        if ((ea_c == 8'hFF) || (eb_c == 8'hFF)) begin
          if (a_nan_c || b_nan_c || (a_inf_c && b_inf_c && (opa_q[31] != opb_q[31]))) begin
            result_d = 32'h7FC0_0000;
            flags_d  = 3'b100;
          end else begin
            result_d = {(a_inf_c ? opa_q[31] : opb_q[31]), 8'hFF, 23'd0};
            flags_d  = 3'b000;
          end
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          sign_d    = sx_c;
          eff_sub_d = sx_c ^ sy_c;
          exp_d     = $signed({2'b00, ex_c});
          mx_d      = {(ex_c != 8'd0), fx_c, 3'b000};
          my_d      = {(ey_c != 8'd0), fy_c, 3'b000};
          cnt_d     = dcl_c;
          state_d   = (dcl_c != 5'd0) ? S_ALIGN : S_ADD;
        end
      end
      S_ALIGN: begin
        // Bits falling off the end are kept alive in the sticky bit
        my_d  = {1'b0, my_q[26:2], my_q[1] | my_q[0]};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_ADD;
      end
      S_ADD: begin
        sum_d  = sum_c;
        zero_d = (sum_c == '0);
        if (sum_c == '0) begin
          sign_d  = 1'b0;
          state_d = S_ROUND;
        end else if (sum_c[27] || !sum_c[26]) begin
          state_d = S_NORM;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_NORM: begin
        if (sum_q[27]) begin
          sum_d   = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
          exp_d   = exp_q + 10'sd1;
          state_d = S_ROUND;
        end else begin
          sum_d = {sum_q[26:0], 1'b0};
          exp_d = exp_q - 10'sd1;
          if (sum_q[25]) state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (zero_q) begin
          result_d = 32'd0;
          flags_d  = 3'b000;
        end else if (exp_fin_c >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          flags_d  = 3'b010;
        end else if (exp_fin_c <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          flags_d  = 3'b001;
        end else begin
          result_d = {sign_q, exp_fin_c[7:0], man_fin_c};
          flags_d  = 3'b000;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed-vector bench for fpu_addsub_seq: results, flags, latency, busy/start
// interlock and mid-operation reset.
module tb_fpu_addsub_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op_sub;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic [2:0]  flags;

  int total = 0;
  int bad   = 0;

  fpu_addsub_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for done; latency counts from the accept edge
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k + 1;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sub, input logic [31:0] exp_r, input logic [2:0] exp_f,
                        input int exp_lat);
    int lat;
    @(negedge clk);
    a = av; b = bv; op_sub = sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_r);
    chk({tag, "_flg"}, 32'(flags), 32'(exp_f));
    @(posedge clk); #1;
    chk({tag, "_idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int lat;
    int done_seen;
    logic [31:0] rne_exp;

    reset = 1'b1; start = 1'b0; op_sub = 1'b0; a = 32'd0; b = 32'd0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_flg", 32'(flags), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

`ifdef FPU_ROUND_NEAREST_EN
    rne_exp = 32'h3F80_0001;
`else
    rne_exp = 32'h3F80_0000;
`endif

    run_op("one_plus_one", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3'b000, 5);
    run_op("exact_zero",   32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h0000_0000, 3'b000, 4);
    run_op("align24",      32'h3F80_0000, 32'h33C0_0000, 1'b0, rne_exp,        3'b000, 28);
    run_op("inf_m_inf",    32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 3'b100, 2);
    run_op("overflow",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b010, 5);
    run_op("two_m_one",    32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 3'b000, 6);
    run_op("one_m_two",    32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 3'b000, 6);
    run_op("nan_in",       32'h3F80_0000, 32'h7FC0_0000, 1'b0, 32'h7FC0_0000, 3'b100, 2);
    run_op("neg_inf",      32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 3'b000, 2);
    run_op("underflow",    32'h00C0_0000, 32'h0080_0000, 1'b1, 32'h0000_0000, 3'b001, 5);
    run_op("denorm_flush", 32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 3'b000, 30);

    // start pulsed while busy must be ignored
    @(negedge clk);
    a = 32'h3F80_0000; b = 32'h3F80_0000; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    a = 32'h7F80_0000; b = 32'h7F80_0000; op_sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int k = 2; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k + 1;
        break;
      end
    end
    chk("busy_start_lat", 32'(lat), 32'd5);
    chk("busy_start_res", result, 32'h4000_0000);
    chk("busy_start_flg", 32'(flags), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_start_no_relaunch", 32'(busy), 32'd0);

    // Reset at cycle 3 of a long operation aborts without a done pulse
    @(negedge clk);
    a = 32'h3F80_0000; b = 32'h33C0_0000; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_res", result, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);

    run_op("after_abort", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3'b000, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
